// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: EX-stage operand forwarding selects, load-use stall/bubble and
// data-memory wait freeze (with timeout release) for a 5-stage RISC-V pipeline.
`default_nettype none

module fwd_hazard_ctrl #(
  parameter int RAW     = 5,
  parameter int TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           id_valid,
  input  logic [RAW-1:0] id_rs1,
  input  logic [RAW-1:0] id_rs2,
  input  logic [RAW-1:0] id_rd,
  input  logic           id_regwrite,
  input  logic           id_memread,
  input  logic           flush,
  input  logic           dmem_ready,
  output logic [1:0]     fwd_a_sel,
  output logic [1:0]     fwd_b_sel,
  output logic           stall_if,
  output logic           stall_id,
  output logic           bubble_ex,
  output logic           stall_all,
  output logic           timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           terr_q, terr_d;

  logic [RAW-1:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d, ex_rd_q, ex_rd_d;
  logic           ex_regwrite_q, ex_regwrite_d, ex_memread_q, ex_memread_d;
  logic [RAW-1:0] mem_rd_q, mem_rd_d;
  logic           mem_regwrite_q, mem_regwrite_d, mem_memread_q, mem_memread_d;
  logic [RAW-1:0] wb_rd_q, wb_rd_d;
  logic           wb_regwrite_q, wb_regwrite_d;

  logic lu, tmo, frz, kill_id;

  function automatic logic [1:0] fwd_sel(input logic [RAW-1:0] src,
                                         input logic mem_we, input logic [RAW-1:0] mem_rd,
                                         input logic wb_we, input logic [RAW-1:0] wb_rd);
    logic [1:0] sel;
    sel = 2'b00;
    if (mem_we && (mem_rd != '0) && (mem_rd == src))
      sel = 2'b10;
    else if (wb_we && (wb_rd != '0) && (wb_rd == src))
      sel = 2'b01;
    return sel;
  endfunction

  always_comb begin
    lu  = id_valid && ex_memread_q && (ex_rd_q != '0) &&
          ((ex_rd_q == id_rs1) || (ex_rd_q == id_rs2));
    // Last permitted wait cycle: release the pipe and treat the load as done.
    tmo = (state_q == S_WAIT) && (cnt_q == CW'(TIMEOUT)) && mem_memread_q && !dmem_ready;
    frz = mem_memread_q && !dmem_ready && !tmo;
    kill_id = lu || flush || !id_valid;

    fwd_a_sel   = fwd_sel(ex_rs1_q, mem_regwrite_q, mem_rd_q, wb_regwrite_q, wb_rd_q);
    fwd_b_sel   = fwd_sel(ex_rs2_q, mem_regwrite_q, mem_rd_q, wb_regwrite_q, wb_rd_q);
    stall_all   = frz;
    stall_if    = lu && !flush && !frz;
    stall_id    = lu && !flush && !frz;
    bubble_ex   = (lu || flush) && !frz && rst_n;
    timeout_err = terr_q;

    state_d = state_q;
    cnt_d   = cnt_q;
    terr_d  = terr_q || tmo;
    case (state_q)
      S_RUN: begin
        if (frz) begin
          state_d = S_WAIT;
          cnt_d   = CW'(1);
        end
      end
      S_WAIT: begin
        if (!frz) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    endcase

    ex_rs1_d       = ex_rs1_q;
    ex_rs2_d       = ex_rs2_q;
    ex_rd_d        = ex_rd_q;
    ex_regwrite_d  = ex_regwrite_q;
    ex_memread_d   = ex_memread_q;
    mem_rd_d       = mem_rd_q;
    mem_regwrite_d = mem_regwrite_q;
    mem_memread_d  = mem_memread_q;
    wb_rd_d        = wb_rd_q;
    wb_regwrite_d  = wb_regwrite_q;
    if (!frz) begin
      wb_rd_d        = mem_rd_q;
      wb_regwrite_d  = mem_regwrite_q;
      mem_rd_d       = ex_rd_q;
      mem_regwrite_d = ex_regwrite_q;
      mem_memread_d  = ex_memread_q;
      ex_rs1_d       = kill_id ? '0 : id_rs1;
      ex_rs2_d       = kill_id ? '0 : id_rs2;
      ex_rd_d        = kill_id ? '0 : id_rd;
      ex_regwrite_d  = kill_id ? 1'b0 : id_regwrite;
      ex_memread_d   = kill_id ? 1'b0 : id_memread;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_RUN;
      cnt_q          <= '0;
      terr_q         <= 1'b0;
      ex_rs1_q       <= '0;
      ex_rs2_q       <= '0;
      ex_rd_q        <= '0;
      ex_regwrite_q  <= 1'b0;
      ex_memread_q   <= 1'b0;
      mem_rd_q       <= '0;
      mem_regwrite_q <= 1'b0;
      mem_memread_q  <= 1'b0;
      wb_rd_q        <= '0;
      wb_regwrite_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      terr_q         <= terr_d;
      ex_rs1_q       <= ex_rs1_d;
      ex_rs2_q       <= ex_rs2_d;
      ex_rd_q        <= ex_rd_d;
      ex_regwrite_q  <= ex_regwrite_d;
      ex_memread_q   <= ex_memread_d;
      mem_rd_q       <= mem_rd_d;
      mem_regwrite_q <= mem_regwrite_d;
      mem_memread_q  <= mem_memread_d;
      wb_rd_q        <= wb_rd_d;
      wb_regwrite_q  <= wb_regwrite_d;
    end
  end

endmodule

`default_nettype wire
